// File: rtl/plab3_mem_prefetch_issuer.sv
`default_nettype none
// ============================================================================
// Module   : plab3_mem_prefetch_issuer
// Purpose  : Next-line PRELW prefetch issuer with credit throttling,
//            page-bounded sequences and last-line de-duplication.
// Revision : 1.0 - initial release
// ============================================================================
module plab3_mem_prefetch_issuer #(
    parameter int p_degree          = 2,
    parameter int p_max_outstanding = 4,
    parameter int p_opaque_nbits    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      miss_val,
    output logic                      miss_rdy,
    input  logic [31:0]               miss_addr,
    input  logic                      flush,
    output logic                      pfreq_val,
    input  logic                      pfreq_rdy,
    output logic [2:0]                pfreq_type,
    output logic [p_opaque_nbits-1:0] pfreq_opaque,
    output logic [31:0]               pfreq_addr,
    output logic [1:0]                pfreq_len,
    output logic [31:0]               pfreq_data,
    input  logic                      pfresp_val,
    output logic                      pfresp_rdy,
    input  logic [p_opaque_nbits-1:0] pfresp_opaque,
    output logic                      busy,
    output logic [3:0]                outstanding,
    output logic                      err_unexpected
);

    localparam logic [2:0]                c_TYPE_PRELW = 3'd3;
    localparam logic [2:0]                c_DEGREE     = 3'(p_degree);
    localparam logic [3:0]                c_MAX_OUT    = 4'(p_max_outstanding);
    localparam logic [p_opaque_nbits-1:0] c_OPQ_ONE    = {{(p_opaque_nbits-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                    r_state;
    logic [27:0]               r_q_mem [2];
    logic                      r_q_head;
    logic [1:0]                r_q_count;
    logic [27:0]               r_base_line;
    logic [27:0]               r_last_line;
    logic                      r_last_valid;
    logic [2:0]                r_k;
    logic [p_opaque_nbits-1:0] r_opq;
    logic [3:0]                r_outstanding;
    logic                      r_err;

    logic [27:0] w_cand;
    logic        w_cross;
    logic        w_dup;
    logic        w_stall;
    logic        w_issue;
    logic        w_q_empty;
    logic        w_q_full;
    logic        w_q_tail;
    logic        w_push;
    logic        w_pop;
    logic        w_unused;

    assign w_cand    = r_base_line + {25'd0, r_k};
    // Page is 4 KiB = 256 lines, so line bits [27:8] identify the page.
    assign w_cross   = (w_cand[27:8] != r_base_line[27:8]);
    assign w_dup     = r_last_valid && (w_cand == r_last_line);
    assign w_stall   = (r_outstanding == c_MAX_OUT);
    assign w_issue   = pfreq_val && pfreq_rdy;
    assign w_q_empty = (r_q_count == 2'd0);
    assign w_q_full  = (r_q_count == 2'd2);
    assign w_q_tail  = r_q_head ^ r_q_count[0];
    assign w_push    = miss_val && !w_q_full && !flush;
    assign w_pop     = (r_state == ST_IDLE) && !w_q_empty && !flush;
    assign w_unused  = ^{pfresp_opaque, miss_addr[3:0]};

    assign miss_rdy       = !w_q_full;
    assign pfreq_val      = (r_state == ST_ISSUE) && !w_cross && !w_dup && !w_stall;
    assign pfreq_type     = c_TYPE_PRELW;
    assign pfreq_opaque   = r_opq;
    assign pfreq_addr     = {w_cand, 4'b0000};
    assign pfreq_len      = 2'd0;
    assign pfreq_data     = 32'd0;
    assign pfresp_rdy     = 1'b1;
    assign busy           = (r_state != ST_IDLE) || !w_q_empty;
    assign outstanding    = r_outstanding;
    assign err_unexpected = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_mem[w_q_tail] <= miss_addr[31:4];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q_head  <= 1'b0;
            r_q_count <= 2'd0;
        end else if (flush) begin
            r_q_head  <= 1'b0;
            r_q_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_q_head <= ~r_q_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_q_count <= r_q_count + 2'd1;
                2'b01:   r_q_count <= r_q_count - 2'd1;
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_base_line   <= 28'd0;
            r_k           <= 3'd0;
            r_last_line   <= 28'd0;
            r_last_valid  <= 1'b0;
            r_opq         <= '0;
            r_outstanding <= 4'd0;
            r_err         <= 1'b0;
        end else begin
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_q_empty) begin
                            r_base_line <= r_q_mem[r_q_head];
                            r_k         <= 3'd1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (w_cross) begin
                            r_state <= ST_IDLE;
                        end else if (w_dup || w_issue) begin
                            if (r_k == c_DEGREE) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_k <= r_k + 3'd1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            if (w_issue) begin
                r_last_line  <= w_cand;
                r_last_valid <= 1'b1;
                r_opq        <= r_opq + c_OPQ_ONE;
            end

            // A response with no credit in flight is flagged and never underflows.
            if (pfresp_val && (r_outstanding == 4'd0)) begin
                r_err <= 1'b1;
            end
            case ({w_issue, pfresp_val})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= (r_outstanding == 4'd0) ? 4'd0 : r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plab3_mem_prefetch_issuer.sv
`default_nettype none
// Scoreboard bench for plab3_mem_prefetch_issuer: a transaction-level next-line
// model predicts every request; directed segments cover flush, errors and reset.
module tb_plab3_mem_prefetch_issuer;

    localparam int DEG  = 2;
    localparam int MAXO = 3;
    localparam int OW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss_val;
    logic          miss_rdy;
    logic [31:0]   miss_addr;
    logic          flush;
    logic          pfreq_val;
    logic          pfreq_rdy;
    logic [2:0]    pfreq_type;
    logic [OW-1:0] pfreq_opaque;
    logic [31:0]   pfreq_addr;
    logic [1:0]    pfreq_len;
    logic [31:0]   pfreq_data;
    logic          pfresp_val;
    logic          pfresp_rdy;
    logic [OW-1:0] pfresp_opaque;
    logic          busy;
    logic [3:0]    outstanding;
    logic          err_unexpected;

    always #5 clk = ~clk;

    plab3_mem_prefetch_issuer #(
        .p_degree          (DEG),
        .p_max_outstanding (MAXO),
        .p_opaque_nbits    (OW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .miss_val       (miss_val),
        .miss_rdy       (miss_rdy),
        .miss_addr      (miss_addr),
        .flush          (flush),
        .pfreq_val      (pfreq_val),
        .pfreq_rdy      (pfreq_rdy),
        .pfreq_type     (pfreq_type),
        .pfreq_opaque   (pfreq_opaque),
        .pfreq_addr     (pfreq_addr),
        .pfreq_len      (pfreq_len),
        .pfreq_data     (pfreq_data),
        .pfresp_val     (pfresp_val),
        .pfresp_rdy     (pfresp_rdy),
        .pfresp_opaque  (pfresp_opaque),
        .busy           (busy),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected)
    );

    typedef struct packed {
        logic [31:0]   addr;
        logic [OW-1:0] opq;
    } req_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   sb_en  = 1'b0;
    req_t exp_q[$];

    logic [27:0]   m_last;
    bit            m_last_valid;
    logic [OW-1:0] m_opq;
    int            m_out;
    bit            prev_stall;
    logic [31:0]   prev_addr;
    logic [OW-1:0] prev_opq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the requests a miss produces, given the last issued line.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_last_valid = 1'b0;
            m_last       = '0;
            m_opq        = '0;
            m_out        = 0;
            prev_stall   = 1'b0;
        end else if (sb_en) begin
            check("outstanding", {28'd0, outstanding}, m_out[31:0]);
            if (prev_stall) begin
                check("hold_val", {31'd0, pfreq_val}, 32'd1);
                check("hold_addr", pfreq_addr, prev_addr);
                check("hold_opq", {24'd0, pfreq_opaque}, {24'd0, prev_opq});
            end
            if (pfreq_val && pfreq_rdy) begin
                req_t e;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", pfreq_addr, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", pfreq_addr, e.addr);
                    check("req_opq", {24'd0, pfreq_opaque}, {24'd0, e.opq});
                    check("req_type", {29'd0, pfreq_type}, 32'd3);
                    check("req_len_data", {30'd0, pfreq_len} | pfreq_data, 32'd0);
                end
                m_out++;
            end
            if (pfresp_val && m_out > 0) m_out--;
            prev_stall = pfreq_val && !pfreq_rdy;
            prev_addr  = pfreq_addr;
            prev_opq   = pfreq_opaque;

            if (miss_val && miss_rdy && !flush) begin
                logic [27:0] base;
                logic [27:0] cand;
                base = miss_addr[31:4];
                for (int k = 1; k <= DEG; k++) begin
                    cand = base + 28'(k);
                    if (cand[27:8] != base[27:8]) break;
                    if (m_last_valid && cand == m_last) continue;
                    exp_q.push_back('{addr: {cand, 4'b0000}, opq: m_opq});
                    m_last       = cand;
                    m_last_valid = 1'b1;
                    m_opq        = m_opq + 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        miss_val   = 1'b0;
        flush      = 1'b0;
        pfresp_val = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_1000 + (32'($urandom_range(0, 3)) << 4);
            1:       return 32'h0000_1FD0 + (32'($urandom_range(0, 5)) << 3);
            2:       return 32'hFFFF_FFD0 + (32'($urandom_range(0, 3)) << 4);
            3:       return 32'h0000_2000 + (32'($urandom_range(0, 15)) << 4);
            default: return $urandom;
        endcase
    endfunction

    // Inject one miss and check the issue slot two cycles later.
    task automatic miss_expect(input logic [31:0] a, input bit exp_val, input logic [31:0] exp_addr);
        tick();
        miss_val  = 1'b1;
        miss_addr = a;
        tick();
        miss_val = 1'b0;
        tick();
        @(negedge clk);
        check("t2_val", {31'd0, pfreq_val}, {31'd0, exp_val});
        if (exp_val) check("t2_addr", pfreq_addr, exp_addr);
    endtask

    initial begin
        reset         = 1'b1;
        miss_val      = 1'b0;
        miss_addr     = '0;
        flush         = 1'b0;
        pfreq_rdy     = 1'b1;
        pfresp_val    = 1'b0;
        pfresp_opaque = '0;
        do_reset();

        @(negedge clk);
        check("rst_miss_rdy", {31'd0, miss_rdy}, 32'd1);
        check("rst_pfreq_val", {31'd0, pfreq_val}, 32'd0);
        check("rst_pfresp_rdy", {31'd0, pfresp_rdy}, 32'd1);
        check("rst_outstanding", {28'd0, outstanding}, 32'd0);
        check("rst_err", {31'd0, err_unexpected}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Basic next-line issue with timing
        sb_en = 1'b1;
        miss_expect(32'h0000_1004, 1'b1, 32'h0000_1010);
        check("basic_opq0", {24'd0, pfreq_opaque}, 32'd0);
        @(negedge clk);
        check("basic_second", pfreq_addr, 32'h0000_1020);
        check("basic_opq1", {24'd0, pfreq_opaque}, 32'd1);
        @(negedge clk);
        check("basic_out", {28'd0, outstanding}, 32'd2);

        // Page crossing and address wrap end the sequence with no request
        miss_expect(32'h0000_1FF8, 1'b0, 32'd0);
        @(negedge clk);
        check("page_busy_t3", {31'd0, busy}, 32'd0);
        miss_expect(32'hFFFF_FFF0, 1'b0, 32'd0);

        // Randomized traffic against the scoreboard
        repeat (600) begin
            tick();
            miss_val   = ($urandom_range(0, 2) == 0);
            miss_addr  = pick_addr();
            pfreq_rdy  = ($urandom_range(0, 3) != 0);
            pfresp_val = (m_out > 0) && ($urandom_range(0, 2) == 0);
        end
        miss_val  = 1'b0;
        pfreq_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            pfresp_val = (m_out > 0);
            if (!busy && !pfreq_val && m_out == 0 && exp_q.size() == 0) break;
        end
        @(negedge clk);
        check("drain_sb_empty", exp_q.size(), 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);
        sb_en = 1'b0;

        // Backpressure hold, then flush
        do_reset();
        pfreq_rdy = 1'b0;
        tick();
        miss_val  = 1'b1;
        miss_addr = 32'h0000_3000;
        tick();
        miss_addr = 32'h0000_5000;
        tick();
        miss_val = 1'b0;
        @(negedge clk);
        check("bp_val", {31'd0, pfreq_val}, 32'd1);
        check("bp_addr", pfreq_addr, 32'h0000_3010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_val", {31'd0, pfreq_val}, 32'd1);
            check("bp_hold_addr", pfreq_addr, 32'h0000_3010);
            check("bp_hold_opq", {24'd0, pfreq_opaque}, 32'd0);
        end
        pfreq_rdy = 1'b1;
        tick();
        pfreq_rdy = 1'b0;
        @(negedge clk);
        check("bp_next_addr", pfreq_addr, 32'h0000_3020);
        check("bp_next_opq", {24'd0, pfreq_opaque}, 32'd1);
        flush     = 1'b1;
        miss_val  = 1'b1;
        miss_addr = 32'h0000_7000;
        tick();
        flush    = 1'b0;
        miss_val = 1'b0;
        @(negedge clk);
        check("flush_val", {31'd0, pfreq_val}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_out", {28'd0, outstanding}, 32'd1);
        repeat (3) @(negedge clk);
        check("flush_quiet", {31'd0, pfreq_val | busy}, 32'd0);
        // last_line 0x301 survives flush: k=1 is skipped, k=2 issues with opaque 1
        pfreq_rdy = 1'b1;
        miss_expect(32'h0000_3000, 1'b0, 32'd0);
        @(negedge clk);
        check("post_flush_val", {31'd0, pfreq_val}, 32'd1);
        check("post_flush_addr", pfreq_addr, 32'h0000_3020);
        check("post_flush_opq", {24'd0, pfreq_opaque}, 32'd1);

        // Unexpected response and asynchronous reset
        do_reset();
        tick();
        pfresp_val = 1'b1;
        tick();
        pfresp_val = 1'b0;
        @(negedge clk);
        check("err_set", {31'd0, err_unexpected}, 32'd1);
        check("err_out0", {28'd0, outstanding}, 32'd0);
        pfreq_rdy = 1'b1;
        miss_expect(32'h0000_4000, 1'b1, 32'h0000_4010);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_val", {31'd0, pfreq_val}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_out", {28'd0, outstanding}, 32'd0);
        check("async_err", {31'd0, err_unexpected}, 32'd0);
        check("async_miss_rdy", {31'd0, miss_rdy}, 32'd1);
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        pfresp_val = 1'b1;
        tick();
        pfresp_val = 1'b0;
        @(negedge clk);
        check("late_resp_err", {31'd0, err_unexpected}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
